// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// The master side is the FSM; the slave side is the datapath that obeys it.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       alu_bcond;
  logic       halt_req;

  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] wd_sel;
  logic       is_halted;

  modport master (
    input  opcode, mem_ready, alu_bcond, halt_req,
    output i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wd_sel,
           is_halted
  );

  modport slave (
    output opcode, mem_ready, alu_bcond, halt_req,
    input  i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, wd_sel,
           is_halted
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select/enable.
module multicycle_control_fsm #(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_fsm_if.master      ctrl
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX     = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_PC4    = 4'd7,
    S_BR     = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; combinational logic below uses blocking assignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= state_next;
  end

  // NOTE: every output and state_next gets a default before the case, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next         = state;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.pc_source     = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = 2'b00;
    ctrl.alu_op        = 2'b00;
    ctrl.reg_write     = 1'b0;
    ctrl.wd_sel        = 2'b00;
    ctrl.is_halted     = 1'b0;

    unique case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        // Gating with reset keeps IR/MDR untouched while reset holds us in IF.
        ctrl.ir_write = ctrl.mem_ready & ~reset;
        if (ctrl.mem_ready) state_next = S_ID;
      end

      S_ID: begin
        ctrl.alu_src_b = 2'b10;
        unique case (ctrl.opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR: state_next = S_EX;
          OP_BRANCH: state_next = S_BR;
          OP_JAL:    state_next = S_JUMP;
          OP_SYSTEM: state_next = (HALT_ON_ECALL && ctrl.halt_req) ? S_HALT : S_PC4;
          default:   state_next = S_PC4;
        endcase
      end

      S_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        unique case (ctrl.opcode)
          OP_R: begin
            ctrl.alu_src_b = 2'b00;
            ctrl.alu_op    = 2'b10;
            state_next     = S_WB_ALU;
          end
          OP_I: begin
            ctrl.alu_op = 2'b10;
            state_next  = S_WB_ALU;
          end
          OP_LOAD:  state_next = S_MEM_RD;
          OP_STORE: state_next = S_MEM_WR;
          OP_JALR:  state_next = S_JUMP;
          default:  state_next = S_PC4;
        endcase
      end

      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        if (ctrl.mem_ready) state_next = S_WB_MEM;
      end

      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (ctrl.mem_ready) state_next = S_PC4;
      end

      S_WB_ALU, S_WB_MEM, S_PC4: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
        ctrl.reg_write = (state != S_PC4);
        ctrl.wd_sel    = (state == S_WB_MEM) ? 2'b01 : 2'b00;
        state_next     = S_IF;
      end

      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        state_next         = ctrl.alu_bcond ? S_IF : S_PC4;
      end

      S_JUMP: begin
        // ALU computes the link value PC+4 while PC loads the target in ALUOut.
        ctrl.alu_src_b = 2'b01;
        ctrl.reg_write = 1'b1;
        ctrl.wd_sel    = 2'b10;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 1'b1;
        state_next     = S_IF;
      end

      S_HALT: ctrl.is_halted = 1'b1;

      default: state_next = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares the full control word against hand-coded values.
module tb_multicycle_control_fsm;

  // Control word packing, MSB first:
  // i_or_d mem_read mem_write ir_write pc_write pc_write_cond pc_source
  // alu_src_a alu_src_b[1:0] alu_op[1:0] reg_write wd_sel[1:0] is_halted
  localparam logic [15:0] W_RESET   = 16'h4000;
  localparam logic [15:0] W_IF      = 16'h5000;
  localparam logic [15:0] W_IF_WAIT = 16'h4000;
  localparam logic [15:0] W_ID      = 16'h0080;
  localparam logic [15:0] W_EX_R    = 16'h0120;
  localparam logic [15:0] W_EX_I    = 16'h01A0;
  localparam logic [15:0] W_EX_ADDR = 16'h0180;
  localparam logic [15:0] W_MEM_RD  = 16'hC000;
  localparam logic [15:0] W_MEM_WR  = 16'hA000;
  localparam logic [15:0] W_PC4     = 16'h0840;
  localparam logic [15:0] W_WB_ALU  = 16'h0848;
  localparam logic [15:0] W_WB_MEM  = 16'h084A;
  localparam logic [15:0] W_BR      = 16'h0710;
  localparam logic [15:0] W_JUMP    = 16'h0A4C;
  localparam logic [15:0] W_HALT    = 16'h0001;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.HALT_ON_ECALL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  always #5 clk = ~clk;

  wire [15:0] word = {bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                      bus.pc_write, bus.pc_write_cond, bus.pc_source,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                      bus.wd_sel, bus.is_halted};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already set: compare the control word
  // plus the exclusivity rules, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    #1;
    check(tag, word, exp);
    check({tag, "_excl"}, {14'd0, bus.mem_read & bus.mem_write,
                           bus.pc_write & bus.pc_write_cond}, 16'd0);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [6:0] op, input logic rdy, input logic bc, input logic hr);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.alu_bcond = bc;
    bus.halt_req  = hr;
  endtask

  initial begin
    reset = 1'b1;
    set_in(7'b0110011, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cyc("reset", W_RESET);
    reset = 1'b0;

    // R-type add: IF ID EX WB_ALU, back to IF on cycle 5
    cyc("r_if", W_IF);
    cyc("r_id", W_ID);
    cyc("r_ex", W_EX_R);
    cyc("r_wb", W_WB_ALU);

    // I-arith, also covers a fetch stall in IF
    set_in(7'b0010011, 1'b0, 1'b0, 1'b0);
    cyc("i_if_wait", W_IF_WAIT);
    bus.mem_ready = 1'b1;
    cyc("i_if", W_IF);
    cyc("i_id", W_ID);
    cyc("i_ex", W_EX_I);
    cyc("i_wb", W_WB_ALU);

    // LOAD with two wait cycles in MEM_RD: 7 cycles total
    set_in(7'b0000011, 1'b1, 1'b0, 1'b0);
    cyc("ld_if", W_IF);
    cyc("ld_id", W_ID);
    cyc("ld_ex", W_EX_ADDR);
    bus.mem_ready = 1'b0;
    cyc("ld_mem_w0", W_MEM_RD);
    cyc("ld_mem_w1", W_MEM_RD);
    bus.mem_ready = 1'b1;
    cyc("ld_mem", W_MEM_RD);
    cyc("ld_wb", W_WB_MEM);

    // Branch taken: IF ID BR
    set_in(7'b1100011, 1'b1, 1'b1, 1'b0);
    cyc("bt_if", W_IF);
    cyc("bt_id", W_ID);
    cyc("bt_br", W_BR);

    // Branch not taken: IF ID BR PC4
    set_in(7'b1100011, 1'b1, 1'b0, 1'b0);
    cyc("bn_if", W_IF);
    cyc("bn_id", W_ID);
    cyc("bn_br", W_BR);
    cyc("bn_pc4", W_PC4);

    // JAL: IF ID JUMP, no EX
    set_in(7'b1101111, 1'b1, 1'b0, 1'b0);
    cyc("jal_if", W_IF);
    cyc("jal_id", W_ID);
    cyc("jal_jump", W_JUMP);

    // JALR: IF ID EX JUMP
    set_in(7'b1100111, 1'b1, 1'b0, 1'b0);
    cyc("jalr_if", W_IF);
    cyc("jalr_id", W_ID);
    cyc("jalr_ex", W_EX_ADDR);
    cyc("jalr_jump", W_JUMP);

    // Unknown opcode executes as NOP
    set_in(7'b0000000, 1'b1, 1'b0, 1'b1);
    cyc("nop_if", W_IF);
    cyc("nop_id", W_ID);
    cyc("nop_pc4", W_PC4);

    // Non-halting ECALL
    set_in(7'b1110011, 1'b1, 1'b0, 1'b0);
    cyc("ecall_if", W_IF);
    cyc("ecall_id", W_ID);
    cyc("ecall_pc4", W_PC4);

    // STORE, reset lands in a MEM_WR wait cycle
    set_in(7'b0100011, 1'b1, 1'b0, 1'b0);
    cyc("st_if", W_IF);
    cyc("st_id", W_ID);
    cyc("st_ex", W_EX_ADDR);
    bus.mem_ready = 1'b0;
    cyc("st_mem_w0", W_MEM_WR);
    cyc("st_mem_w1", W_MEM_WR);
    reset = 1'b1;
    cyc("st_reset_now", W_RESET);
    bus.mem_ready = 1'b1;
    cyc("st_reset_hold", W_RESET);
    reset = 1'b0;

    // Fresh STORE after reset, no waits: 5 cycles
    cyc("st2_if", W_IF);
    cyc("st2_id", W_ID);
    cyc("st2_ex", W_EX_ADDR);
    cyc("st2_mem", W_MEM_WR);
    cyc("st2_pc4", W_PC4);

    // Halting ECALL: HALT is terminal regardless of inputs
    set_in(7'b1110011, 1'b1, 1'b0, 1'b1);
    cyc("halt_if", W_IF);
    cyc("halt_id", W_ID);
    for (int i = 0; i < 22; i++) begin
      set_in((i % 2 == 0) ? 7'b0110011 : 7'b0000011, i[0], i[1], 1'b0);
      cyc($sformatf("halt_%0d", i), W_HALT);
    end

    // Reset recovers from HALT
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    cyc("halt_reset", W_RESET);
    reset = 1'b0;
    cyc("post_halt_if", W_IF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
